// File: rtl/sdram_port_arb_pkg.sv
// Shared definitions for the two-port SDRAM arbiter: grant FSM encoding,
// requester id type and the default depth of the outstanding-tag FIFO.
package sdram_port_arb_pkg;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_GNT0 = 2'd1,
      ST_GNT1 = 2'd2
   } arb_state_e;

   typedef logic port_id_t;

   localparam int TAG_DEPTH_DEF = 4;

endpackage

// File: rtl/sdram_port_arb_if.sv
// Bundle of both requester ports and the SDRAM core inport.
// The slave modport is the arbiter's view; master is the driver's view.
interface sdram_port_arb_if;

   logic [3:0]  p0_wr_i,         p1_wr_i;
   logic        p0_rd_i,         p1_rd_i;
   logic [7:0]  p0_len_i,        p1_len_i;
   logic [31:0] p0_addr_i,       p1_addr_i;
   logic [31:0] p0_write_data_i, p1_write_data_i;
   logic        p0_accept_o,     p1_accept_o;
   logic        p0_ack_o,        p1_ack_o;
   logic        p0_error_o,      p1_error_o;
   logic [31:0] p0_read_data_o,  p1_read_data_o;

   logic [3:0]  ram_wr_o;
   logic        ram_rd_o;
   logic [7:0]  ram_len_o;
   logic [31:0] ram_addr_o;
   logic [31:0] ram_write_data_o;
   logic        ram_accept_i;
   logic        ram_ack_i;
   logic        ram_error_i;
   logic [31:0] ram_read_data_i;

   modport slave (
      input  p0_wr_i, p1_wr_i, p0_rd_i, p1_rd_i, p0_len_i, p1_len_i,
             p0_addr_i, p1_addr_i, p0_write_data_i, p1_write_data_i,
      output p0_accept_o, p1_accept_o, p0_ack_o, p1_ack_o,
             p0_error_o, p1_error_o, p0_read_data_o, p1_read_data_o,
      output ram_wr_o, ram_rd_o, ram_len_o, ram_addr_o, ram_write_data_o,
      input  ram_accept_i, ram_ack_i, ram_error_i, ram_read_data_i
   );

   modport master (
      output p0_wr_i, p1_wr_i, p0_rd_i, p1_rd_i, p0_len_i, p1_len_i,
             p0_addr_i, p1_addr_i, p0_write_data_i, p1_write_data_i,
      input  p0_accept_o, p1_accept_o, p0_ack_o, p1_ack_o,
             p0_error_o, p1_error_o, p0_read_data_o, p1_read_data_o,
      input  ram_wr_o, ram_rd_o, ram_len_o, ram_addr_o, ram_write_data_o,
      output ram_accept_i, ram_ack_i, ram_error_i, ram_read_data_i
   );

endinterface

// File: rtl/sdram_arb_tag_fifo.sv
// In-order FIFO of requester ids for accepted-but-unacked SDRAM accesses.
// Push while full and pop while empty are ignored.
module sdram_arb_tag_fifo
   import sdram_port_arb_pkg::*;
#(
   parameter int DEPTH = TAG_DEPTH_DEF
) (
   input  logic     clk_i,
   input  logic     rst_n_i,
   input  logic     push_i,
   input  port_id_t data_i,
   input  logic     pop_i,
   output port_id_t data_o,
   output logic     full_o,
   output logic     empty_o
);

   localparam int AW = $clog2(DEPTH);
   localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

   port_id_t        mem_q [DEPTH];
   logic [AW-1:0]   wr_ptr_q, rd_ptr_q;
   logic [AW:0]     count_q;
   logic            do_push, do_pop;

   assign full_o  = (count_q == FULL_CNT);
   assign empty_o = (count_q == '0);
   assign do_push = push_i && !full_o;
   assign do_pop  = pop_i && !empty_o;
   assign data_o  = mem_q[rd_ptr_q];

   always_ff @(posedge clk_i) begin
      if (do_push) mem_q[wr_ptr_q] <= data_i;
   end

   // Pointers are power-of-two wide, so they wrap for free.
   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
         if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
         case ({do_push, do_pop})
            2'b10:   count_q <= count_q + 1'b1;
            2'b01:   count_q <= count_q - 1'b1;
            default: count_q <= count_q;
         endcase
      end
   end

endmodule

// File: rtl/sdram_port_arb.sv
// Round-robin arbiter sharing one SDRAM core inport between two requesters;
// grants hold for a whole burst and acks are routed back by an in-order tag FIFO.
module sdram_port_arb
   import sdram_port_arb_pkg::*;
#(
   parameter int TAG_DEPTH = TAG_DEPTH_DEF
) (
   input  logic             clk_i,
   input  logic             rst_n_i,
   sdram_port_arb_if.slave  bus,
   output logic             proto_err_o
);

   arb_state_e state_q, state_d;
   port_id_t   last_q, last_d;
   logic [7:0] cnt_q, cur_cnt;
   logic       burst_q;
   logic       req0, req1, gnt0, gnt1;
   logic       acc0, acc1, acc_any, burst_end;
   logic       full, empty, pop;
   port_id_t   head;

   assign req0    = (bus.p0_wr_i != 4'h0) || bus.p0_rd_i;
   assign req1    = (bus.p1_wr_i != 4'h0) || bus.p1_rd_i;
   assign gnt0    = (state_q == ST_GNT0);
   assign gnt1    = (state_q == ST_GNT1);
   assign acc0    = bus.ram_accept_i && gnt0 && !full;
   assign acc1    = bus.ram_accept_i && gnt1 && !full;
   assign acc_any = acc0 || acc1;

   // The first accept of a grant takes the length straight from the port;
   // afterwards the latched count is authoritative.
   assign cur_cnt   = burst_q ? cnt_q : (gnt1 ? bus.p1_len_i : bus.p0_len_i);
   assign burst_end = acc_any && (cur_cnt == 8'd0);

   assign bus.p0_accept_o = acc0;
   assign bus.p1_accept_o = acc1;

   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         state_q <= ST_IDLE;
         last_q  <= 1'b1;
      end else begin
         state_q <= state_d;
         last_q  <= last_d;
      end
   end

   always_comb begin
      state_d              = state_q;
      last_d               = last_q;
      bus.ram_wr_o         = 4'h0;
      bus.ram_rd_o         = 1'b0;
      bus.ram_len_o        = 8'h0;
      bus.ram_addr_o       = 32'h0;
      bus.ram_write_data_o = 32'h0;
      case (state_q)
         ST_IDLE: begin
            if (req0 && req1)  state_d = (last_q == 1'b0) ? ST_GNT1 : ST_GNT0;
            else if (req0)     state_d = ST_GNT0;
            else if (req1)     state_d = ST_GNT1;
         end
         ST_GNT0: begin
            bus.ram_wr_o         = full ? 4'h0 : bus.p0_wr_i;
            bus.ram_rd_o         = bus.p0_rd_i && !full;
            bus.ram_len_o        = bus.p0_len_i;
            bus.ram_addr_o       = bus.p0_addr_i;
            bus.ram_write_data_o = bus.p0_write_data_i;
            if (burst_end) begin
               state_d = ST_IDLE;
               last_d  = 1'b0;
            end
         end
         ST_GNT1: begin
            bus.ram_wr_o         = full ? 4'h0 : bus.p1_wr_i;
            bus.ram_rd_o         = bus.p1_rd_i && !full;
            bus.ram_len_o        = bus.p1_len_i;
            bus.ram_addr_o       = bus.p1_addr_i;
            bus.ram_write_data_o = bus.p1_write_data_i;
            if (burst_end) begin
               state_d = ST_IDLE;
               last_d  = 1'b1;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         cnt_q   <= 8'h0;
         burst_q <= 1'b0;
      end else if (acc_any) begin
         if (burst_end) begin
            cnt_q   <= 8'h0;
            burst_q <= 1'b0;
         end else begin
            cnt_q   <= cur_cnt - 8'd1;
            burst_q <= 1'b1;
         end
      end
   end

   sdram_arb_tag_fifo #(.DEPTH(TAG_DEPTH)) u_tag_fifo (
      .clk_i   (clk_i),
      .rst_n_i (rst_n_i),
      .push_i  (acc_any),
      .data_i  (gnt1),
      .pop_i   (pop),
      .data_o  (head),
      .full_o  (full),
      .empty_o (empty)
   );

   // An ack with nothing outstanding is swallowed and flagged.
   assign pop             = bus.ram_ack_i && !empty;
   assign bus.p0_ack_o    = pop && (head == 1'b0);
   assign bus.p1_ack_o    = pop && (head == 1'b1);
   assign bus.p0_error_o  = bus.p0_ack_o && bus.ram_error_i;
   assign bus.p1_error_o  = bus.p1_ack_o && bus.ram_error_i;
   assign bus.p0_read_data_o = bus.ram_read_data_i;
   assign bus.p1_read_data_o = bus.ram_read_data_i;

   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i)                     proto_err_o <= 1'b0;
      else if (bus.ram_ack_i && empty)  proto_err_o <= 1'b1;
   end

endmodule

// File: tb/tb_sdram_port_arb.sv
// Self-checking bench for sdram_port_arb: a per-cycle vector table plus
// hand sequences for FIFO-full blocking and ack routing via a tag scoreboard.
module tb_sdram_port_arb;

   localparam logic [31:0] A0 = 32'h0000_0100;
   localparam logic [31:0] A1 = 32'h0000_0200;
   localparam logic [31:0] RD = 32'hDEAD_BEEF;

   typedef struct {
      logic        rst;
      logic [3:0]  p0_wr;  logic p0_rd;  logic [7:0] p0_len;
      logic [3:0]  p1_wr;  logic p1_rd;  logic [7:0] p1_len;
      logic        acc;    logic ack;    logic err;
      logic [1:0]  e_acc;  logic [1:0] e_ack; logic [1:0] e_err;
      logic [3:0]  e_wr;   logic e_rd;   logic [31:0] e_addr; logic e_proto;
   } vec_t;

   logic clk_i = 1'b0;
   logic rst_n_i;
   logic proto_err_o;
   int   checks = 0;
   int   errors = 0;
   bit   exp_q[$];
   vec_t tbl[$];

   sdram_port_arb_if bus();

   sdram_port_arb #(.TAG_DEPTH(4)) dut (
      .clk_i       (clk_i),
      .rst_n_i     (rst_n_i),
      .bus         (bus.slave),
      .proto_err_o (proto_err_o)
   );

   always #5 clk_i = ~clk_i;

   function automatic vec_t mk(
      logic rst, logic [3:0] p0w, logic p0r, logic [7:0] p0l,
      logic [3:0] p1w, logic p1r, logic [7:0] p1l,
      logic acc, logic ack, logic err,
      logic [1:0] ea, logic [1:0] ek, logic [1:0] ee,
      logic [3:0] ew, logic er, logic [31:0] ead, logic ep);
      vec_t v;
      v.rst = rst; v.p0_wr = p0w; v.p0_rd = p0r; v.p0_len = p0l;
      v.p1_wr = p1w; v.p1_rd = p1r; v.p1_len = p1l;
      v.acc = acc; v.ack = ack; v.err = err;
      v.e_acc = ea; v.e_ack = ek; v.e_err = ee;
      v.e_wr = ew; v.e_rd = er; v.e_addr = ead; v.e_proto = ep;
      return v;
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s act=%h exp=%h", name, act, exp);
      end
   endtask

   task automatic step();
      @(posedge clk_i);
      #1;
   endtask

   task automatic clear_inputs();
      bus.p0_wr_i = 4'h0; bus.p0_rd_i = 1'b0; bus.p0_len_i = 8'h0;
      bus.p1_wr_i = 4'h0; bus.p1_rd_i = 1'b0; bus.p1_len_i = 8'h0;
      bus.ram_accept_i = 1'b0; bus.ram_ack_i = 1'b0; bus.ram_error_i = 1'b0;
   endtask

   task automatic reset_dut();
      clear_inputs();
      rst_n_i = 1'b0;
      step();
      rst_n_i = 1'b1;
   endtask

   // Pops the expected owner of the current ack and checks routing and error.
   task automatic sb_check(input string tag);
      bit   e;
      logic err;
      err = bus.ram_error_i;
      if (exp_q.size() == 0) begin
         checks++;
         errors++;
         $display("FAIL %s_sb act=empty exp=entry", tag);
      end else begin
         e = exp_q.pop_front();
         chk({tag, "_ack"}, {bus.p1_ack_o, bus.p0_ack_o}, e ? 2'b10 : 2'b01);
         chk({tag, "_err"}, {bus.p1_error_o, bus.p0_error_o},
             err ? (e ? 2'b10 : 2'b01) : 2'b00);
      end
   endtask

   initial begin
      int n_acc;
      logic [1:0] pat [6];
      rst_n_i = 1'b0;
      clear_inputs();
      bus.p0_addr_i = A0; bus.p0_write_data_i = 32'hA0A0_A0A0;
      bus.p1_addr_i = A1; bus.p1_write_data_i = 32'hB1B1_B1B1;
      bus.ram_read_data_i = RD;

      // single p0 read, then ack
      tbl.push_back(mk(0, 0,0,0, 0,0,0, 0,0,0, 0,0,0, 0,0,0, 0));
      tbl.push_back(mk(1, 0,1,0, 0,0,0, 1,0,0, 0,0,0, 0,0,0, 0));
      tbl.push_back(mk(1, 0,1,0, 0,0,0, 1,0,0, 1,0,0, 0,1,A0,0));
      tbl.push_back(mk(1, 0,0,0, 0,0,0, 1,1,0, 0,1,0, 0,0,0, 0));
      tbl.push_back(mk(1, 0,0,0, 0,0,0, 0,0,0, 0,0,0, 0,0,0, 0));
      // both ports writing every cycle: grants alternate
      tbl.push_back(mk(0, 0,0,0, 0,0,0, 0,0,0, 0,0,0, 0,0,0, 0));
      tbl.push_back(mk(1, 4'hF,0,0, 4'h3,0,0, 1,0,0, 0,0,0, 0,0,0, 0));
      tbl.push_back(mk(1, 4'hF,0,0, 4'h3,0,0, 1,0,0, 1,0,0, 4'hF,0,A0,0));
      tbl.push_back(mk(1, 4'hF,0,0, 4'h3,0,0, 1,1,0, 0,1,0, 0,0,0, 0));
      tbl.push_back(mk(1, 4'hF,0,0, 4'h3,0,0, 1,0,0, 2,0,0, 4'h3,0,A1,0));
      tbl.push_back(mk(1, 4'hF,0,0, 4'h3,0,0, 1,1,1, 0,2,2, 0,0,0, 0));
      tbl.push_back(mk(1, 4'hF,0,0, 4'h3,0,0, 1,0,0, 1,0,0, 4'hF,0,A0,0));
      tbl.push_back(mk(1, 0,0,0, 0,0,0, 1,1,0, 0,1,0, 0,0,0, 0));
      // p1 burst of 4 holds off p0; later len_i change ignored; FIFO fills
      tbl.push_back(mk(0, 0,0,0, 0,0,0, 0,0,0, 0,0,0, 0,0,0, 0));
      tbl.push_back(mk(1, 0,0,0, 0,1,3, 1,0,0, 0,0,0, 0,0,0, 0));
      tbl.push_back(mk(1, 0,1,0, 0,1,3, 1,0,0, 2,0,0, 0,1,A1,0));
      tbl.push_back(mk(1, 0,1,0, 0,1,0, 1,0,0, 2,0,0, 0,1,A1,0));
      tbl.push_back(mk(1, 0,1,0, 0,1,0, 1,0,0, 2,0,0, 0,1,A1,0));
      tbl.push_back(mk(1, 0,1,0, 0,1,0, 1,0,0, 2,0,0, 0,1,A1,0));
      tbl.push_back(mk(1, 0,1,0, 0,0,0, 1,0,0, 0,0,0, 0,0,0, 0));
      tbl.push_back(mk(1, 0,1,0, 0,0,0, 1,0,0, 0,0,0, 0,0,A0,0));
      tbl.push_back(mk(1, 0,1,0, 0,0,0, 1,1,0, 0,2,0, 0,0,A0,0));
      tbl.push_back(mk(1, 0,1,0, 0,0,0, 1,0,0, 1,0,0, 0,1,A0,0));
      tbl.push_back(mk(1, 0,0,0, 0,0,0, 1,1,0, 0,2,0, 0,0,0, 0));
      tbl.push_back(mk(1, 0,0,0, 0,0,0, 1,1,0, 0,2,0, 0,0,0, 0));
      tbl.push_back(mk(1, 0,0,0, 0,0,0, 1,1,0, 0,2,0, 0,0,0, 0));
      tbl.push_back(mk(1, 0,0,0, 0,0,0, 1,1,0, 0,1,0, 0,0,0, 0));
      // stray ack, then reset mid-burst, then stray ack again
      tbl.push_back(mk(1, 0,0,0, 0,0,0, 0,1,0, 0,0,0, 0,0,0, 0));
      tbl.push_back(mk(1, 0,0,0, 0,0,0, 0,0,0, 0,0,0, 0,0,0, 1));
      tbl.push_back(mk(1, 0,1,3, 0,0,0, 1,0,0, 0,0,0, 0,0,0, 1));
      tbl.push_back(mk(1, 0,1,3, 0,0,0, 1,0,0, 1,0,0, 0,1,A0,1));
      tbl.push_back(mk(1, 0,1,3, 0,0,0, 1,0,0, 1,0,0, 0,1,A0,1));
      tbl.push_back(mk(0, 0,1,3, 0,0,0, 1,0,0, 0,0,0, 0,0,0, 0));
      tbl.push_back(mk(1, 0,0,0, 0,0,0, 1,1,0, 0,0,0, 0,0,0, 0));
      tbl.push_back(mk(1, 0,0,0, 0,0,0, 0,0,0, 0,0,0, 0,0,0, 1));

      step();
      foreach (tbl[i]) begin
         rst_n_i = tbl[i].rst;
         bus.p0_wr_i = tbl[i].p0_wr; bus.p0_rd_i = tbl[i].p0_rd; bus.p0_len_i = tbl[i].p0_len;
         bus.p1_wr_i = tbl[i].p1_wr; bus.p1_rd_i = tbl[i].p1_rd; bus.p1_len_i = tbl[i].p1_len;
         bus.ram_accept_i = tbl[i].acc; bus.ram_ack_i = tbl[i].ack; bus.ram_error_i = tbl[i].err;
         #2;
         chk($sformatf("r%0d_accept", i), {bus.p1_accept_o, bus.p0_accept_o}, tbl[i].e_acc);
         chk($sformatf("r%0d_ack", i), {bus.p1_ack_o, bus.p0_ack_o}, tbl[i].e_ack);
         chk($sformatf("r%0d_error", i), {bus.p1_error_o, bus.p0_error_o}, tbl[i].e_err);
         chk($sformatf("r%0d_ram_wr", i), bus.ram_wr_o, tbl[i].e_wr);
         chk($sformatf("r%0d_ram_rd", i), bus.ram_rd_o, tbl[i].e_rd);
         chk($sformatf("r%0d_ram_addr", i), bus.ram_addr_o, tbl[i].e_addr);
         chk($sformatf("r%0d_proto", i), proto_err_o, tbl[i].e_proto);
         chk($sformatf("r%0d_rdata", i), bus.p0_read_data_o ^ bus.p1_read_data_o ^ RD, RD);
         step();
      end

      // p0 issues back-to-back reads with acks withheld: only 4 fit
      reset_dut();
      bus.p0_rd_i = 1'b1; bus.ram_accept_i = 1'b1;
      n_acc = 0;
      for (int c = 0; c < 14; c++) begin
         #2;
         if (n_acc == 4) chk($sformatf("full_rd_c%0d", c), bus.ram_rd_o, 1'b0);
         if (bus.p0_accept_o) begin
            n_acc++;
            exp_q.push_back(1'b0);
         end
         step();
      end
      chk("full_acc_count", n_acc, 4);
      bus.ram_ack_i = 1'b1;
      #2;
      chk("full_pop_blocks_acc", bus.p0_accept_o, 1'b0);
      sb_check("full_ack0");
      step();
      bus.ram_ack_i = 1'b0;
      #2;
      chk("fifth_acc", bus.p0_accept_o, 1'b1);
      exp_q.push_back(1'b0);
      step();
      bus.p0_rd_i = 1'b0;
      for (int k = 0; k < 4; k++) begin
         bus.ram_ack_i = 1'b1;
         #2;
         sb_check($sformatf("drain%0d", k));
         step();
      end
      bus.ram_ack_i = 1'b0;

      // interleaved grants, error reported on the 2nd ack only
      reset_dut();
      pat = '{2'b00, 2'b01, 2'b00, 2'b10, 2'b00, 2'b01};
      bus.p0_rd_i = 1'b1; bus.p1_rd_i = 1'b1; bus.ram_accept_i = 1'b1;
      for (int c = 0; c < 6; c++) begin
         #2;
         chk($sformatf("il_acc%0d", c), {bus.p1_accept_o, bus.p0_accept_o}, pat[c]);
         if (pat[c] == 2'b01) exp_q.push_back(1'b0);
         if (pat[c] == 2'b10) exp_q.push_back(1'b1);
         step();
      end
      clear_inputs();
      for (int k = 0; k < 3; k++) begin
         bus.ram_ack_i = 1'b1;
         bus.ram_error_i = (k == 1);
         #2;
         sb_check($sformatf("il_ack%0d", k));
         step();
      end
      clear_inputs();
      chk("sb_drained", exp_q.size(), 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/sdram_port_arb.md
SDRAM_PORT_ARB -- requirements
Module: sdram_port_arb

Interface
REQ-001 SHALL have parameter TAG_DEPTH, default 4, meaning the maximum number of accepted requests awaiting ack (power of 2, 2..16).
REQ-002 SHALL have port clk_i, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-003 SHALL have port rst_n_i, input, 1 bit: reset, asynchronous, active-low.
REQ-004 SHALL have, per requester p in {0,1}, inputs p<p>_wr_i [3:0] (byte write strobes), p<p>_rd_i [1], p<p>_len_i [7:0] (burst length minus 1), p<p>_addr_i [31:0] and p<p>_write_data_i [31:0].
REQ-005 SHALL have, per requester, outputs p<p>_accept_o [1], p<p>_ack_o [1], p<p>_error_o [1] and p<p>_read_data_o [31:0].
REQ-006 SHALL have downstream outputs ram_wr_o [3:0], ram_rd_o [1], ram_len_o [7:0], ram_addr_o [31:0] and ram_write_data_o [31:0], all driving the SDRAM core inport.
REQ-007 SHALL have downstream inputs ram_accept_i [1], ram_ack_i [1], ram_error_i [1] and ram_read_data_i [31:0].
REQ-008 SHALL have output proto_err_o [1]: sticky flag, set by an ack received with no outstanding tag.

Function
REQ-009 A port SHALL be "requesting" when its wr_i != 0 or its rd_i = 1.
REQ-010 The grant FSM SHALL have states IDLE, GNT0 and GNT1.
REQ-011 In IDLE with requests present, the FSM SHALL move next cycle to the GNT state of the requesting port; if both ports request, it SHALL pick the port not in last_q (round robin).
REQ-012 Grant SHALL be registered: there is 1 cycle of latency from the request in IDLE to its forwarding downstream.
REQ-013 In GNTp, ram_* request outputs SHALL be the combinational copy of port p's inputs, gated to zero (wr=0, rd=0) while the tag FIFO is full; in IDLE they SHALL be all zero.
REQ-014 p<p>_accept_o SHALL equal ram_accept_i AND (state==GNTp) AND NOT fifo_full; the other port's accept_o SHALL be 0.
REQ-015 On the first accept in a grant, the burst counter SHALL load p<p>_len_i; later len_i values in the same grant are ignored.
REQ-016 On each later accept, the burst counter SHALL decrement.
REQ-017 The accept that occurs with count==0 (len_i==0 for a single access) SHALL end the grant: state becomes IDLE and last_q becomes p in the next cycle.
REQ-018 The grant SHALL be held until the burst completes, even if the granted port deasserts its request mid-burst; the other port waits.
REQ-019 Each accept SHALL push the granted port's id into an in-order tag FIFO of depth TAG_DEPTH.
REQ-020 Each ram_ack_i SHALL pop the head tag and, in the same cycle (combinationally), assert that port's ack_o, with error_o = ram_error_i.
REQ-021 ram_read_data_i SHALL be broadcast to both read_data_o outputs.
REQ-022 On simultaneous push and pop, the FIFO occupancy SHALL be unchanged.
REQ-023 When full, the FIFO SHALL block accepts even if a pop occurs in the same cycle.
REQ-024 An ack with the FIFO empty SHALL be dropped (no port ack), and proto_err_o SHALL set and remain set until reset.
REQ-025 FIFO pointers SHALL wrap modulo TAG_DEPTH; occupancy SHALL be a counter of width clog2(TAG_DEPTH)+1.

Reset
REQ-026 On rst_n_i low, regardless of clock, the block SHALL force state=IDLE, last_q=1 (so port 0 wins first), burst count=0, FIFO empty and proto_err_o=0.
REQ-027 While in reset, all accept/ack/error outputs and ram_wr_o/ram_rd_o SHALL be 0.
REQ-028 Reset asserted mid-burst SHALL discard all outstanding tags; later acks SHALL then be handled per REQ-024.

Structure
REQ-029 The shared sdram package SHALL hold the FSM state encoding, the port-id type and the TAG_DEPTH default.
REQ-030 The tag FIFO SHALL be a sub-module, sdram_arb_tag_fifo (sync FIFO, 1-bit data, full/empty flags).

Verification
REQ-031 Bench scenario: p0 single rd @0x100, len=0, core accepts at once -> ram_rd_o high 1 cycle after request, p0_accept_o 1 cycle, later ram_ack_i -> p0_ack_o only.
REQ-032 Bench scenario: both ports request single writes every cycle from reset -> grants alternate p0,p1,p0,p1; no port gets two consecutive grants.
REQ-033 Bench scenario: p1 burst len=3 while p0 requests -> 4 consecutive p1 accepts before the first p0 grant.
REQ-034 Bench scenario: TAG_DEPTH=4, core withholds ack, p0 issues 6 reads -> exactly 4 accepted; ram_rd_o=0 while full; one ack -> 5th read accepted the cycle after.
REQ-035 Bench scenario: interleaved p0/p1 accepts then acks with ram_error_i=1 on the 2nd -> acks route in accept order; the error appears only on the 2nd port's error_o.
REQ-036 Bench scenario: ram_ack_i with the FIFO empty, then rst_n_i pulsed mid-burst -> proto_err_o=1 and no port ack; after reset proto_err_o=0, state IDLE.
